// File: rtl/lram_pkg.sv
// Shared types for the local-RAM arbiter: ownership states, bus widths, read tag.
// The optional build macro LRAM_ARB_RR_EN is consumed by lram_arb, not here.
package lram_pkg;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int BCNT_W = 4;

  typedef logic [0:ADDR_W-1] addr_t;
  typedef logic [0:DATA_W-1] data_t;
  typedef logic [BCNT_W-1:0] bcnt_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_t;

  // One in-flight read: whether it is a real read, and which port gets the data.
  typedef struct packed {
    logic valid;
    logic port;
  } tag_t;

  function automatic bcnt_t bcnt_inc(input bcnt_t b);
    return (b == '1) ? b : b + 1'b1;
  endfunction

endpackage

// File: rtl/lram_rdtag.sv
// Read tag delay line: carries {valid, port} alongside the RAM read latency so
// returning data can be steered to the port that issued the read.
module lram_rdtag
  import lram_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic sys_clk,
  input  logic reset,
  input  tag_t push,
  output tag_t tail
);

  tag_t pipe [DEPTH];

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      // NOTE: unlike a RAM array this small delay line must be cleared, or
      // stale valid bits would fire rvalid for reads dropped by reset.
      for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
    end else begin
      // NOTE: non-blocking updates let every stage read its neighbour's old value.
      pipe[0] <= push;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign tail = pipe[DEPTH-1];

endmodule

// File: rtl/lram_arb.sv
// Two-port arbiter/sequencer for the 1024x32 local RAM (registered I/O, RD_LAT read).
// Build option: define LRAM_ARB_RR_EN for round-robin tie-break from IDLE.
module lram_arb
  import lram_pkg::*;
#(
  parameter int MAX_BURST = 4,
  parameter int RD_LAT    = 2
) (
  input  logic  sys_clk,
  input  logic  reset,
  input  logic  req0,
  input  logic  req1,
  input  logic  we0,
  input  logic  we1,
  input  addr_t a0,
  input  addr_t a1,
  input  data_t din0,
  input  data_t din1,
  output logic  gnt0,
  output logic  gnt1,
  output logic  rvalid0,
  output logic  rvalid1,
  output data_t dout,
  output logic  ram_cs,
  output logic  ram_we,
  output addr_t ram_a,
  output data_t ram_din,
  input  data_t ram_dout
);

  localparam bcnt_t BURST_LIM = bcnt_t'(MAX_BURST);

  state_t state_q, state_d;
  bcnt_t  bcnt_q, bcnt_d;
  addr_t  hold_a;
  data_t  hold_din;
  logic   prefer0;
  logic   any_gnt;
  logic   sel_we;
  addr_t  sel_a;
  data_t  sel_din;
  tag_t   tag_push, tag_tail;

`ifdef LRAM_ARB_RR_EN
  // Last owner; port 0 wins a tie from IDLE unless it was the last owner.
  logic last_q;

  always_ff @(posedge sys_clk) begin
    if (reset)        last_q <= 1'b1;
    else if (any_gnt) last_q <= gnt1;
  end

  assign prefer0 = last_q;
`else
  assign prefer0 = 1'b1;
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path infers a latch.
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    state_d = state_q;
    bcnt_d  = bcnt_q;
    if (!reset) begin
      case (state_q)
        ST_IDLE: begin
          if (req0 && (!req1 || prefer0)) begin
            gnt0    = 1'b1;
            state_d = ST_OWN0;
            bcnt_d  = bcnt_t'(1);
          end else if (req1) begin
            gnt1    = 1'b1;
            state_d = ST_OWN1;
            bcnt_d  = bcnt_t'(1);
          end
        end
        ST_OWN0: begin
          if (req0 && (!req1 || bcnt_q < BURST_LIM)) begin
            gnt0   = 1'b1;
            bcnt_d = bcnt_inc(bcnt_q);
          end else if (req1) begin
            gnt1    = 1'b1;
            state_d = ST_OWN1;
            bcnt_d  = bcnt_t'(1);
          end else begin
            state_d = ST_IDLE;
            bcnt_d  = '0;
          end
        end
        ST_OWN1: begin
          if (req1 && (!req0 || bcnt_q < BURST_LIM)) begin
            gnt1   = 1'b1;
            bcnt_d = bcnt_inc(bcnt_q);
          end else if (req0) begin
            gnt0    = 1'b1;
            state_d = ST_OWN0;
            bcnt_d  = bcnt_t'(1);
          end else begin
            state_d = ST_IDLE;
            bcnt_d  = '0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          bcnt_d  = '0;
        end
      endcase
    end
  end

  assign any_gnt = gnt0 | gnt1;
  assign sel_we  = gnt1 ? we1  : we0;
  assign sel_a   = gnt1 ? a1   : a0;
  assign sel_din = gnt1 ? din1 : din0;

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      bcnt_q   <= '0;
      hold_a   <= '0;
      hold_din <= '0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      // RAM address/data hold their last value on idle cycles to avoid toggling.
      if (any_gnt) begin
        hold_a   <= sel_a;
        hold_din <= sel_din;
      end
    end
  end

  assign ram_cs  = ~any_gnt;
  assign ram_we  = any_gnt ? ~sel_we : 1'b1;
  assign ram_a   = any_gnt ? sel_a   : hold_a;
  assign ram_din = any_gnt ? sel_din : hold_din;

  assign tag_push = '{valid: any_gnt & ~sel_we, port: gnt1};

  lram_rdtag #(
    .DEPTH (RD_LAT)
  ) u_rdtag (
    .sys_clk (sys_clk),
    .reset   (reset),
    .push    (tag_push),
    .tail    (tag_tail)
  );

  // Gate with reset so a read in flight when reset rises never reports.
  assign rvalid0 = ~reset & tag_tail.valid & ~tag_tail.port;
  assign rvalid1 = ~reset & tag_tail.valid &  tag_tail.port;
  assign dout    = ram_dout;

endmodule

// File: tb/tb_lram_arb.sv
// Self-checking bench for lram_arb: directed scenarios then random traffic,
// checked against an ownership/burst model, a read scoreboard and a shadow RAM.
module tb_lram_arb;

  localparam int MAX_BURST = 4;
  localparam int RD_LAT    = 2;
`ifdef LRAM_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        req_v [2];
  logic        we_v  [2];
  logic [0:9]  a_v   [2];
  logic [0:31] din_v [2];
  logic        gnt0, gnt1, rvalid0, rvalid1, ram_cs, ram_we;
  logic [0:31] dout, ram_din, ram_dout;
  logic [0:9]  ram_a;

  lram_arb #(.MAX_BURST(MAX_BURST), .RD_LAT(RD_LAT)) dut (
    .sys_clk (clk),      .reset   (rst),
    .req0    (req_v[0]), .req1    (req_v[1]),
    .we0     (we_v[0]),  .we1     (we_v[1]),
    .a0      (a_v[0]),   .a1      (a_v[1]),
    .din0    (din_v[0]), .din1    (din_v[1]),
    .gnt0    (gnt0),     .gnt1    (gnt1),
    .rvalid0 (rvalid0),  .rvalid1 (rvalid1),
    .dout    (dout),     .ram_cs  (ram_cs),
    .ram_we  (ram_we),   .ram_a   (ram_a),
    .ram_din (ram_din),  .ram_dout(ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input int i);
    return (i == 5) ? 32'hDEADBEEF : (32'(i) * 32'h9E3779B9) ^ 32'h5A5A0000;
  endfunction

  // RAM model: inputs latched at the edge, data out RD_LAT edges later.
  logic [31:0] mem [1024];
  logic [0:31] ram_pipe [RD_LAT];
  bit          mem_ready = 1'b0;
  assign ram_dout = ram_pipe[RD_LAT-1];

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_val(i);
      mem_ready <= 1'b1;
    end else if (!ram_cs && !ram_we) begin
      mem[ram_a] <= ram_din;
    end
    ram_pipe[0] <= mem[ram_a];
    for (int i = 1; i < RD_LAT; i++) ram_pipe[i] <= ram_pipe[i-1];
  end

  typedef struct {
    int          port;
    logic [31:0] data;
    int          due;
  } rd_t;

  rd_t         rd_q [$];
  logic [31:0] exp_mem [1024];
  int          glog [$];
  int          n_vec = 0, n_bad = 0;
  int          cyc = 0;
  int          owner = -1, run = 0, last_win = 1;
  logic [31:0] last_a = 0, last_din = 0;
  bit          known = 1'b0;
  bit          keep [2];
  int          last_g = -1;
  int          last_rv_port = -1;
  logic [31:0] last_rv_data = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock cycle: predict, compare at the falling edge, advance the model.
  task automatic step();
    int g, o, p;
    rd_t e;
    @(negedge clk);
    g = -1;
    if (!rst) begin
      if (owner < 0) begin
        if (req_v[0] && req_v[1]) g = (RR_EN && last_win == 0) ? 1 : 0;
        else if (req_v[0])        g = 0;
        else if (req_v[1])        g = 1;
      end else begin
        o = owner;
        p = 1 - o;
        if (req_v[o] && (!req_v[p] || run < MAX_BURST)) g = o;
        else if (req_v[p])                               g = p;
      end
    end
    check("gnt0", 32'(gnt0), 32'(g == 0));
    check("gnt1", 32'(gnt1), 32'(g == 1));
    if (known) begin
      check("ram_cs", 32'(ram_cs), 32'(g < 0));
      check("ram_we", 32'(ram_we), (g < 0) ? 32'd1 : 32'(!we_v[g]));
      check("ram_a", 32'(ram_a), (g < 0) ? last_a : 32'(a_v[g]));
      check("ram_din", ram_din, (g < 0) ? last_din : din_v[g]);
    end
    if (!rst && rd_q.size() > 0 && rd_q[0].due == cyc) begin
      e = rd_q.pop_front();
      check("rvalid0", 32'(rvalid0), 32'(e.port == 0));
      check("rvalid1", 32'(rvalid1), 32'(e.port == 1));
      check("dout", dout, e.data);
      last_rv_port = e.port;
      last_rv_data = dout;
    end else begin
      check("rvalid0_idle", 32'(rvalid0), 32'd0);
      check("rvalid1_idle", 32'(rvalid1), 32'd0);
    end

    if (rst) begin
      rd_q.delete();
      owner = -1; run = 0; last_win = 1;
      last_a = 0; last_din = 0;
      known = 1'b1;
    end else if (g >= 0) begin
      glog.push_back(g);
      if (we_v[g]) exp_mem[a_v[g]] = din_v[g];
      else rd_q.push_back('{port: g, data: exp_mem[a_v[g]], due: cyc + RD_LAT});
      last_a   = 32'(a_v[g]);
      last_din = din_v[g];
      run      = (g == owner) ? ((run < 15) ? run + 1 : 15) : 1;
      owner    = g;
      last_win = g;
    end else begin
      owner = -1;
      run   = 0;
    end
    last_g = g;
    cyc++;
    @(posedge clk);
    #1;
    if (g >= 0 && !keep[g]) req_v[g] = 1'b0;
  endtask

  task automatic set_req(input int p, input logic we, input logic [0:9] a, input logic [0:31] d);
    req_v[p] = 1'b1;
    we_v[p]  = we;
    a_v[p]   = a;
    din_v[p] = d;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  int burst_exp [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};

  initial begin
    for (int i = 0; i < 1024; i++) exp_mem[i] = init_val(i);
    rst = 1'b1;
    for (int p = 0; p < 2; p++) begin
      req_v[p] = 1'b0; we_v[p] = 1'b0; a_v[p] = '0; din_v[p] = '0; keep[p] = 1'b0;
    end
    @(posedge clk); #1;
    steps(3);
    rst = 1'b0;

    // Single read of address 5.
    set_req(0, 1'b0, 10'h005, 32'h0);
    step();
    check("t1_gnt", 32'(last_g), 32'd0);
    steps(2);
    check("t1_port", 32'(last_rv_port), 32'd0);
    check("t1_data", last_rv_data, 32'hDEADBEEF);

    // Port 1 write then read-back of 0x3FF.
    set_req(1, 1'b1, 10'h3FF, 32'h12345678);
    step();
    set_req(1, 1'b0, 10'h3FF, 32'h0);
    steps(3);
    check("t2_port", 32'(last_rv_port), 32'd1);
    check("t2_data", last_rv_data, 32'h12345678);
    steps(2);

    // Burst limit with both ports requesting continuously.
    keep[0] = 1'b1; keep[1] = 1'b1;
    set_req(0, 1'b1, 10'h010, 32'hA0A0A0A0);
    set_req(1, 1'b1, 10'h011, 32'hB1B1B1B1);
    glog.delete();
    steps(9);
    for (int i = 0; i < 9; i++) check($sformatf("t3_burst%0d", i), 32'(glog[i]), 32'(burst_exp[i]));
    keep[0] = 1'b0; keep[1] = 1'b0;
    req_v[0] = 1'b0; req_v[1] = 1'b0;
    steps(4);

    // Ties from IDLE after reset.
    rst = 1'b1;
    steps(1);
    rst = 1'b0;
    set_req(0, 1'b0, 10'h001, 32'h0);
    set_req(1, 1'b0, 10'h002, 32'h0);
    step();
    check("t4_tie1", 32'(last_g), 32'd0);
    req_v[1] = 1'b0;
    steps(2);
    set_req(0, 1'b0, 10'h001, 32'h0);
    set_req(1, 1'b0, 10'h002, 32'h0);
    step();
    check("t4_tie2", 32'(last_g), RR_EN ? 32'd1 : 32'd0);
    steps(4);

    // Reset one cycle after a read grant.
    set_req(0, 1'b0, 10'h007, 32'h0);
    step();
    rst = 1'b1;
    set_req(0, 1'b0, 10'h008, 32'h0);
    step();
    rst = 1'b0;
    step();
    check("t5_first_gnt", 32'(last_g), 32'd0);
    steps(4);

    // Interleaved port reads of 0x001 / 0x002.
    for (int i = 0; i < 6; i++) begin
      set_req(i % 2, 1'b0, (i % 2) ? 10'h002 : 10'h001, 32'h0);
      step();
    end
    steps(3);
    check("t6_last_port", 32'(last_rv_port), 32'd1);
    check("t6_last_data", last_rv_data, exp_mem[2]);

    // Random traffic over a small address window to force write/read hazards.
    for (int c = 0; c < 800; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!req_v[p]) begin
          if ($urandom_range(3) != 0)
            set_req(p, 1'($urandom_range(1)), 10'($urandom_range(15)), $urandom);
        end else if ($urandom_range(15) == 0) begin
          req_v[p] = 1'b0;
        end
      end
      rst = ($urandom_range(199) == 0);
      step();
    end
    rst = 1'b0;
    req_v[0] = 1'b0; req_v[1] = 1'b0;
    steps(RD_LAT + 2);
    check("final_queue_empty", 32'(rd_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
